// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: sync, blanking, windowed active flag, scaled coordinates,
// frame pulses and frame counter. Optional per-line interrupt is enabled with `define VGA_LINE_IRQ_EN.
module vga_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   SCALE_SH = 1,
    parameter int   WIN_Y0   = 60,
    parameter int   WIN_Y1   = 420,
    parameter int   XW       = 10,
    parameter int   YW       = 9,
    parameter int   FRAME_W  = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_pix_stb,
`ifdef VGA_LINE_IRQ_EN
    input  logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0] i_irq_line,
    output logic               o_line_irq,
`endif
    output logic               o_hs,
    output logic               o_vs,
    output logic               o_blanking,
    output logic               o_active,
    output logic               o_screenend,
    output logic               o_animate,
    output logic [XW-1:0]      o_x,
    output logic [YW-1:0]      o_y,
    output logic [FRAME_W-1:0] o_frame
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] ANI_V  = VW'(WIN_Y1 - 1);

    // Decode thresholds are kept 32 bits wide so an end bound equal to the total never overflows.
    localparam logic [31:0] HS_START = 32'(H_ACTIVE + H_FP);
    localparam logic [31:0] HS_END   = 32'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [31:0] VS_START = 32'(V_ACTIVE + V_FP);
    localparam logic [31:0] VS_END   = 32'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [31:0] H_ACT32  = 32'(H_ACTIVE);
    localparam logic [31:0] V_ACT32  = 32'(V_ACTIVE);
    localparam logic [31:0] WY0      = 32'(WIN_Y0);
    localparam logic [31:0] WY1      = 32'(WIN_Y1);
    localparam logic [31:0] Y_CLAMP  = 32'((WIN_Y1 - WIN_Y0 - 1) >> SCALE_SH);

    logic [HW-1:0]      hCount_q, hCount_d;
    logic [VW-1:0]      vCount_q, vCount_d;
    logic               hs_q, hs_d;
    logic               vs_q, vs_d;
    logic               blank_q, blank_d;
    logic               active_q, active_d;
    logic               screenEnd_q, screenEnd_d;
    logic               animate_q, animate_d;
    logic [XW-1:0]      x_q, x_d;
    logic [YW-1:0]      y_q, y_d;
    logic [FRAME_W-1:0] frame_q, frame_d;

    logic [31:0]        hExt, vExt;
    logic               hLast, vLast;
    logic               hsDec, vsDec, blankDec, activeDec;
    logic [XW-1:0]      xDec;
    logic [YW-1:0]      yDec;

    assign hExt  = 32'(hCount_q);
    assign vExt  = 32'(vCount_q);
    assign hLast = (hCount_q == H_LAST);
    assign vLast = (vCount_q == V_LAST);

    // Raster position advance; both counters wrap at their totals.
    always_comb begin
        hCount_d = hCount_q;
        vCount_d = vCount_q;
        if (i_pix_stb) begin
            if (hLast) begin
                hCount_d = '0;
                vCount_d = vLast ? '0 : vCount_q + VW'(1);
            end else begin
                hCount_d = hCount_q + HW'(1);
            end
        end
    end

    always_comb begin
        hsDec     = (hExt >= HS_START && hExt < HS_END) ? HS_POL : ~HS_POL;
        vsDec     = (vExt >= VS_START && vExt < VS_END) ? VS_POL : ~VS_POL;
        blankDec  = (hExt >= H_ACT32) || (vExt >= V_ACT32);
        activeDec = (hExt < H_ACT32) && (vExt >= WY0) && (vExt < WY1);
        xDec      = '0;
        if (hExt < H_ACT32) begin
            xDec = XW'(hExt >> SCALE_SH);
        end
        // Above the window the y coordinate pins at 0, below it at the last window row.
        if (vExt < WY0) begin
            yDec = '0;
        end else if (vExt >= WY1) begin
            yDec = YW'(Y_CLAMP);
        end else begin
            yDec = YW'((vExt - WY0) >> SCALE_SH);
        end
    end

    always_comb begin
        hs_d        = hs_q;
        vs_d        = vs_q;
        blank_d     = blank_q;
        active_d    = active_q;
        x_d         = x_q;
        y_d         = y_q;
        frame_d     = frame_q;
        screenEnd_d = 1'b0;
        animate_d   = 1'b0;
        if (i_pix_stb) begin
            hs_d        = hsDec;
            vs_d        = vsDec;
            blank_d     = blankDec;
            active_d    = activeDec;
            x_d         = xDec;
            y_d         = yDec;
            screenEnd_d = hLast && vLast;
            animate_d   = hLast && (vCount_q == ANI_V);
            if (hLast && vLast) begin
                frame_d = frame_q + FRAME_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hCount_q    <= '0;
            vCount_q    <= '0;
            hs_q        <= ~HS_POL;
            vs_q        <= ~VS_POL;
            blank_q     <= 1'b1;
            active_q    <= 1'b0;
            screenEnd_q <= 1'b0;
            animate_q   <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            frame_q     <= '0;
        end else begin
            hCount_q    <= hCount_d;
            vCount_q    <= vCount_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            blank_q     <= blank_d;
            active_q    <= active_d;
            screenEnd_q <= screenEnd_d;
            animate_q   <= animate_d;
            x_q         <= x_d;
            y_q         <= y_d;
            frame_q     <= frame_d;
        end
    end

`ifdef VGA_LINE_IRQ_EN
    logic lineIrq_q, lineIrq_d;

    // A requested line beyond the screen can never equal the v counter, so it never fires.
    always_comb begin
        lineIrq_d = i_pix_stb && hLast && (vCount_q == i_irq_line);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lineIrq_q <= 1'b0;
        end else begin
            lineIrq_q <= lineIrq_d;
        end
    end

    assign o_line_irq = lineIrq_q;
`endif

    assign o_hs        = hs_q;
    assign o_vs        = vs_q;
    assign o_blanking  = blank_q;
    assign o_active    = active_q;
    assign o_screenend = screenEnd_q;
    assign o_animate   = animate_q;
    assign o_x         = x_q;
    assign o_y         = y_q;
    assign o_frame     = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen on a reduced 24x17 raster: a strobe-count model predicts every output
// each cycle, backed by hand-computed expectations at key raster positions.
module tb_vga_timing_gen;

    localparam int HA = 16, HFP = 2, HSY = 3, HBP = 3;
    localparam int VA = 12, VFP = 1, VSY = 2, VBP = 2;
    localparam int HT = HA + HFP + HSY + HBP;
    localparam int VT = VA + VFP + VSY + VBP;
    localparam int FT = HT * VT;
    localparam int VWB = $clog2(VT);
    localparam logic HSP = 1'b0, VSP = 1'b1;
    localparam int SH = 1, WY0 = 3, WY1 = 9;
    localparam int XW = 4, YW = 3, FW = 2;

    logic          clk = 1'b0;
    logic          rstN = 1'b0;
    logic          pixStb = 1'b0;
    logic          oHs, oVs, oBlank, oActive, oScreenEnd, oAnimate;
    logic [XW-1:0] oX;
    logic [YW-1:0] oY;
    logic [FW-1:0] oFrame;
    logic [VWB-1:0] irqLine = VWB'(5);
    logic          lineIrq;

    int  total = 0;
    int  bad = 0;
    bit  checkEn = 1'b0;

    longint n = 0;
    bit     lastStb = 1'b0;
    bit     irqHit = 1'b0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .HS_POL(HSP), .VS_POL(VSP), .SCALE_SH(SH),
        .WIN_Y0(WY0), .WIN_Y1(WY1), .XW(XW), .YW(YW), .FRAME_W(FW)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rstN),
        .i_pix_stb(pixStb),
`ifdef VGA_LINE_IRQ_EN
        .i_irq_line(irqLine),
        .o_line_irq(lineIrq),
`endif
        .o_hs(oHs),
        .o_vs(oVs),
        .o_blanking(oBlank),
        .o_active(oActive),
        .o_screenend(oScreenEnd),
        .o_animate(oAnimate),
        .o_x(oX),
        .o_y(oY),
        .o_frame(oFrame)
    );

`ifndef VGA_LINE_IRQ_EN
    assign lineIrq = 1'b0;
`endif

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s at t=%0t strobes=%0d: got %0d expected %0d", name, $time, n, actual, expected);
        end
    endtask

    // Model state: the number of strobes since reset fully determines the raster position.
    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            n = 0;
            lastStb = 1'b0;
            irqHit = 1'b0;
        end else begin
            lastStb = pixStb;
            irqHit = pixStb && (int'(irqLine) < VT) &&
                     ((n % FT) == longint'(int'(irqLine) * HT + HT - 1));
            if (pixStb) n++;
        end
    end

    always @(negedge clk) begin : compare
        longint p, h, v;
        longint eHs, eVs, eBl, eAc, eX, eY, eSe, eAn, eFr;
        if (checkEn) begin
            if (n == 0) begin
                eHs = !HSP; eVs = !VSP; eBl = 1; eAc = 0; eX = 0; eY = 0;
                eSe = 0; eAn = 0;
            end else begin
                p = (n - 1) % FT;
                h = p % HT;
                v = p / HT;
                eHs = (h >= HA + HFP && h < HA + HFP + HSY) ? HSP : !HSP;
                eVs = (v >= VA + VFP && v < VA + VFP + VSY) ? VSP : !VSP;
                eBl = (h >= HA || v >= VA) ? 1 : 0;
                eAc = (h < HA && v >= WY0 && v < WY1) ? 1 : 0;
                eX  = (h < HA) ? ((h >> SH) % (1 << XW)) : 0;
                if (v < WY0)       eY = 0;
                else if (v >= WY1) eY = ((WY1 - WY0 - 1) >> SH) % (1 << YW);
                else               eY = ((v - WY0) >> SH) % (1 << YW);
                eSe = (lastStb && p == FT - 1) ? 1 : 0;
                eAn = (lastStb && p == (WY1 - 1) * HT + HT - 1) ? 1 : 0;
            end
            eFr = (n / FT) % (1 << FW);
            checkOutput("hs", oHs, eHs);
            checkOutput("vs", oVs, eVs);
            checkOutput("blanking", oBlank, eBl);
            checkOutput("active", oActive, eAc);
            checkOutput("x", oX, eX);
            checkOutput("y", oY, eY);
            checkOutput("screenend", oScreenEnd, eSe);
            checkOutput("animate", oAnimate, eAn);
            checkOutput("frame", oFrame, eFr);
`ifdef VGA_LINE_IRQ_EN
            checkOutput("line_irq", lineIrq, irqHit ? 1 : 0);
`endif
        end
    end

    // mode 0: strobe every clock, 1: every 4th clock, 2: random ~75% density.
    task automatic applyStimulus(input int mode, input int nClk);
        for (int c = 0; c < nClk; c++) begin
            @(negedge clk);
            case (mode)
                0:       pixStb = 1'b1;
                1:       pixStb = (c % 4 == 0);
                default: pixStb = ($urandom_range(0, 3) != 0);
            endcase
        end
        @(negedge clk);
        pixStb = 1'b0;
    endtask

    task automatic stepBy(input int k);
        repeat (k) begin
            @(negedge clk);
            pixStb = 1'b1;
        end
        @(negedge clk);
        pixStb = 1'b0;
    endtask

    task automatic stepTo(input longint target);
        stepBy(int'(target - n));
    endtask

    task automatic countFrame(input int expIrq);
        int hsLow, vsHigh, act, se, an, irq;
        hsLow = 0; vsHigh = 0; act = 0; se = 0; an = 0; irq = 0;
        for (int i = 0; i < FT; i++) begin
            stepBy(1);
            if (oHs == 1'b0) hsLow++;
            if (oVs == 1'b1) vsHigh++;
            if (oActive) act++;
            if (oScreenEnd) se++;
            if (oAnimate) an++;
            if (lineIrq) irq++;
        end
        checkOutput("hs_low_per_frame", hsLow, 3 * 17);
        checkOutput("vs_high_per_frame", vsHigh, 2 * 24);
        checkOutput("active_per_frame", act, 16 * 6);
        checkOutput("screenend_per_frame", se, 1);
        checkOutput("animate_per_frame", an, 1);
`ifdef VGA_LINE_IRQ_EN
        checkOutput("line_irq_per_frame", irq, expIrq);
`else
        if (expIrq < 0) $display("[TB] unused irq expectation");
`endif
    endtask

    initial begin
        rstN = 1'b0;
        pixStb = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkEn = 1'b1;
        checkOutput("rst_hs", oHs, 1);
        checkOutput("rst_vs", oVs, 0);
        checkOutput("rst_blanking", oBlank, 1);
        checkOutput("rst_frame", oFrame, 0);
        rstN = 1'b1;

        $display("[TB] directed raster positions");
        stepTo(1);
        checkOutput("p0_blanking", oBlank, 0);
        checkOutput("p0_hs", oHs, 1);
        stepTo(19);
        checkOutput("h18_hs", oHs, 0);
        stepTo(22);
        checkOutput("h21_hs", oHs, 1);
        stepTo(53);
        checkOutput("v2_active", oActive, 0);
        stepTo(78);
        checkOutput("v3h5_active", oActive, 1);
        checkOutput("v3h5_x", oX, 2);
        stepTo(88);
        checkOutput("v3h15_x", oX, 7);
        stepTo(89);
        checkOutput("v3h16_active", oActive, 0);
        checkOutput("v3h16_x", oX, 0);
        stepTo(216);
        checkOutput("v8h23_animate", oAnimate, 1);
        checkOutput("v8h23_y", oY, 2);
        stepTo(241);
        checkOutput("v10_y", oY, 2);
        stepTo(313);
        checkOutput("v13_vs", oVs, 1);
        stepTo(408);
        checkOutput("end_screenend", oScreenEnd, 1);
        checkOutput("end_frame", oFrame, 1);
        @(negedge clk);
        checkOutput("screenend_cleared", oScreenEnd, 0);

        $display("[TB] full-frame counts");
        countFrame(1);
        checkOutput("frame_after_2", oFrame, 2);
        stepTo(5 * FT);
        checkOutput("frame_after_5_wrap", oFrame, 1);

        $display("[TB] sparse and random strobes");
        applyStimulus(1, 4 * FT);
        irqLine = VWB'(30);
        countFrame(0);
        irqLine = VWB'($urandom_range(0, VT - 1));
        applyStimulus(2, 2000);
        irqLine = VWB'(5);
        applyStimulus(0, 150);

        $display("[TB] asynchronous reset mid-line");
        stepBy(7);
        #2 rstN = 1'b0;
        #1;
        checkOutput("midrst_hs", oHs, 1);
        checkOutput("midrst_vs", oVs, 0);
        checkOutput("midrst_blanking", oBlank, 1);
        checkOutput("midrst_active", oActive, 0);
        checkOutput("midrst_x", oX, 0);
        checkOutput("midrst_frame", oFrame, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;
        stepBy(1);
        checkOutput("postrst_x", oX, 0);
        checkOutput("postrst_blanking", oBlank, 0);
        applyStimulus(2, 300);

        checkEn = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
